wb_sram32_split: RTL and testbench

32-to-16-bit Wishbone width splitter placed directly upstream of the 16-bit SRAM controller. It accepts 32-bit single accesses from the LM32 data/instruction bus, issues one or two 16-bit Wishbone accesses to the controller, assembles read data, and returns a single ack. It is big-endian: `dat[31:16]` maps to the even SRAM halfword.

---
 rtl/wb_sram32_split_pkg.sv | 18 +
 rtl/wb_sram32_split_if.sv | 24 ++
 rtl/wb_sram32_split_lane.sv | 52 +++++
 rtl/wb_sram32_split.sv | 148 ++++++++++++++
 tb/tb_wb_sram32_split.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_sram32_split_pkg.sv
// wb_sram32_split shared definitions
// state codes, half selectors, halfword width
package wb_split_pkg;

  localparam int HW = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_EVEN = 3'd1;
  localparam state_t S_GAP  = 3'd2;
  localparam state_t S_ODD  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  localparam logic HALF_EVEN = 1'b0;
  localparam logic HALF_ODD  = 1'b1;

endpackage

// File: rtl/wb_sram32_split_if.sv
// Wishbone classic bus bundle
// used for both the 32-bit upstream and 16-bit downstream sides
interface wb_sram32_split_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/wb_sram32_split_lane.sv
// halfword lane: write-data/sel steering by half
// and read-data assembly into rd_hi/rd_lo
module wb_split_lane
  import wb_split_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          half,
  input  logic [31:0]   dat_q,
  input  logic [3:0]    sel_q,
  input  logic          clr,
  input  logic          cap_hi,
  input  logic          cap_lo,
  input  logic [HW-1:0] rd_in,
  output logic [31:0]   m_dat,
  output logic [3:0]    m_sel,
  output logic [31:0]   rd_word
);

  logic [HW-1:0] rd_hi;
  logic [HW-1:0] rd_lo;

  // even half carries the upper bits (big-endian)
  always_comb begin
    m_dat = '0;
    m_sel = '0;
    if (half == HALF_ODD) begin
      m_dat[HW-1:0] = dat_q[HW-1:0];
      m_sel[1:0]    = sel_q[1:0];
    end else begin
      m_dat[HW-1:0] = dat_q[31:HW];
      m_sel[1:0]    = sel_q[3:2];
    end
  end

  // capture returned halfwords; cleared on each new request
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hi <= '0;
      rd_lo <= '0;
    end else if (clr) begin
      rd_hi <= '0;
      rd_lo <= '0;
    end else begin
      if (cap_hi) rd_hi <= rd_in;
      if (cap_lo) rd_lo <= rd_in;
    end
  end

  assign rd_word = {rd_hi, rd_lo};

endmodule

// File: rtl/wb_sram32_split.sv
// 32-to-16-bit Wishbone splitter in front of the SRAM controller
// WB_SPLIT_SKIP_EN: skip halves whose two sel bits are zero
module wb_sram32_split
  import wb_split_pkg::*;
#(
  parameter int adr_width = 17
) (
  input  logic clk,
  input  logic reset,
  wb_sram32_split_if.slave  s,
  wb_sram32_split_if.master m
);

  state_t state;
  state_t state_nx;

  logic [adr_width-1:0] adr_q;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [31:0]          dat_q;
  logic                 abort_q;

  logic        ack_w;
  logic        s_req;
  logic        accept;
  logic        abort;
  logic        busy;
  logic        half;
  logic        s_hi;
  logic        s_lo;
  logic        q_lo;
  logic        cap_hi;
  logic        cap_lo;
  logic [31:0] lane_dat;
  logic [3:0]  lane_sel;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign ack_w  = (state == S_DONE);
  assign s_req  = s.stb & s.cyc & ~ack_w;
  assign accept = (state == S_IDLE) & s_req;
  assign abort  = abort_q | ~s.cyc;

`ifdef WB_SPLIT_SKIP_EN
  assign s_hi = |s.sel[3:2];
  assign s_lo = |s.sel[1:0];
  assign q_lo = |sel_q[1:0];
`else
  assign s_hi = 1'b1;
  assign s_lo = 1'b1;
  assign q_lo = 1'b1;
`endif

  assign cap_hi = (state == S_EVEN) & m.ack & ~we_q;
  assign cap_lo = (state == S_ODD) & m.ack & ~we_q;

  assign unused_bits = ^{s.adr[31:adr_width+2], s.adr[1:0], m.dat_r[31:HW]};

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next-state: even, one idle gap, odd, then ack
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (s_req) begin
          if (s_hi)      state_nx = S_EVEN;
          else if (s_lo) state_nx = S_ODD;
          else           state_nx = S_DONE;
        end
      end
      S_EVEN: begin
        if (m.ack) begin
          if (abort)     state_nx = S_IDLE;
          else if (q_lo) state_nx = S_GAP;
          else           state_nx = S_DONE;
        end
      end
      S_GAP:  state_nx = abort ? S_IDLE : S_ODD;
      S_ODD: begin
        if (m.ack) state_nx = abort ? S_IDLE : S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs decode the state register only
  always_comb begin
    busy    = (state == S_EVEN) | (state == S_ODD);
    half    = (state == S_ODD) ? HALF_ODD : HALF_EVEN;
    m.stb   = busy;
    m.cyc   = busy;
    m.we    = busy & we_q;
    m.adr   = {{(29 - adr_width){1'b0}}, adr_q, half, 2'b00};
    m.sel   = lane_sel;
    m.dat_w = lane_dat;
    s.ack   = ack_w;
    s.dat_r = rd_word;
  end

  // latch the upstream request on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (accept) begin
      adr_q <= s.adr[adr_width+1:2];
      we_q  <= s.we;
      sel_q <= s.sel;
      dat_q <= s.dat_w;
    end
  end

  // remember a cycle drop even if cyc comes back before the ack
  always_ff @(posedge clk) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else if (accept) begin
      abort_q <= 1'b0;
    end else if (((state == S_EVEN) | (state == S_GAP) |
                  (state == S_ODD)) & ~s.cyc) begin
      abort_q <= 1'b1;
    end
  end

  wb_split_lane u_lane (
    .clk     (clk),
    .reset   (reset),
    .half    (half),
    .dat_q   (dat_q),
    .sel_q   (sel_q),
    .clr     (accept),
    .cap_hi  (cap_hi),
    .cap_lo  (cap_lo),
    .rd_in   (m.dat_r[HW-1:0]),
    .m_dat   (lane_dat),
    .m_sel   (lane_sel),
    .rd_word (rd_word)
  );

endmodule

// File: tb/tb_wb_sram32_split.sv
// self-checking bench for wb_sram32_split
// WB_SPLIT_SKIP_EN changes the expected access pattern
module tb_wb_sram32_split;

`ifdef WB_SPLIT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } acc_t;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          lat;
    int          exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_sram32_split_if u_s ();
  wb_sram32_split_if u_m ();

  wb_sram32_split #(.adr_width(17)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (u_s),
    .m     (u_m)
  );

  int n_asrt = 0;
  int n_fail = 0;

  int lat = 0;
  int rises = 0;
  int viol = 0;
  logic [15:0] hmem [int];
  logic [31:0] ref_mem [int];
  acc_t acc_q [$];
  acc_t exp_q [$];
  int exp_ack;
  logic [31:0] exp_rd;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // downstream SRAM controller: ack L+1 cycles after strobe rises
  initial begin
    int cnt;
    bit prev_ack;
    bit prev_stb;
    bit nack;
    logic [15:0] nd;
    logic [15:0] h;
    logic [31:0] r;
    int idx;
    acc_t a;
    cnt = 0;
    prev_ack = 0;
    prev_stb = 0;
    u_m.ack = 1'b0;
    u_m.dat_r = '0;
    forever begin
      @(negedge clk);
      nack = 0;
      nd = u_m.dat_r[15:0];
      if (prev_ack && u_m.stb === 1'b1) viol++;
      if (u_m.stb === 1'b1 && !prev_stb) rises++;
      prev_stb = (u_m.stb === 1'b1);
      prev_ack = (u_m.ack === 1'b1);
      if (u_m.ack) begin
        cnt = 0;
      end else if (u_m.stb === 1'b1) begin
        if (cnt == lat) begin
          nack = 1;
          idx = int'(u_m.adr >> 2);
          h = hmem.exists(idx) ? hmem[idx] : 16'h0;
          if (u_m.we) begin
            if (u_m.sel[1]) h[15:8] = u_m.dat_w[15:8];
            if (u_m.sel[0]) h[7:0]  = u_m.dat_w[7:0];
            hmem[idx] = h;
          end else begin
            nd = h;
          end
          a.we = u_m.we;
          a.adr = u_m.adr;
          a.sel = u_m.sel;
          a.dat = u_m.dat_w;
          acc_q.push_back(a);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
      @(posedge clk);
      #1;
      r = $urandom;
      u_m.ack = nack;
      u_m.dat_r = {r[31:16], nd};
    end
  end

  task automatic preload(input int word, input logic [31:0] val);
    ref_mem[word] = val;
    hmem[2*word] = val[31:16];
    hmem[2*word+1] = val[15:0];
  endtask

  // expected accesses, ack latency and read data of one request
  task automatic model_txn(input bit we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input int L);
    int word;
    logic [31:0] cur;
    logic [1:0] s2;
    acc_t a;
    word = int'((adr >> 2) & 32'h1_FFFF);
    cur = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
    exp_q.delete();
    exp_rd = '0;
    for (int h = 0; h < 2; h++) begin
      s2 = (h == 0) ? sel[3:2] : sel[1:0];
      if (!SKIP || s2 != 2'b00) begin
        a.we = we;
        a.adr = 32'(word * 8 + h * 4);
        a.sel = {2'b00, s2};
        a.dat = {16'h0, (h == 0) ? dat[31:16] : dat[15:0]};
        exp_q.push_back(a);
        if (h == 0) exp_rd[31:16] = cur[31:16];
        else        exp_rd[15:0]  = cur[15:0];
      end
    end
    case (exp_q.size())
      2:       exp_ack = 2 * L + 6;
      1:       exp_ack = L + 3;
      default: exp_ack = 1;
    endcase
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) cur[8*b +: 8] = dat[8*b +: 8];
      ref_mem[word] = cur;
    end
  endtask

  task automatic compare_acc(input string tag);
    check({tag, "_nacc"}, acc_q.size(), exp_q.size());
    check({tag, "_nstb"}, rises, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      check($sformatf("%s_adr%0d", tag, i), acc_q[i].adr, exp_q[i].adr);
      check($sformatf("%s_wesel%0d", tag, i),
            {27'd0, acc_q[i].we, acc_q[i].sel},
            {27'd0, exp_q[i].we, exp_q[i].sel});
      if (exp_q[i].we)
        check($sformatf("%s_dat%0d", tag, i), acc_q[i].dat, exp_q[i].dat);
    end
  endtask

  task automatic drive_req(input bit we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat);
    u_s.stb = 1'b1;
    u_s.cyc = 1'b1;
    u_s.we = we;
    u_s.adr = adr;
    u_s.sel = sel;
    u_s.dat_w = dat;
  endtask

  task automatic run_txn(input bit we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input int L, output int ack_off,
                         output logic [31:0] rd);
    int c0;
    bit got;
    lat = L;
    @(posedge clk);
    #1;
    acc_q.delete();
    rises = 0;
    drive_req(we, adr, sel, dat);
    c0 = cyc_cnt;
    got = 0;
    ack_off = -1;
    rd = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (u_s.ack === 1'b1) begin
        got = 1;
        ack_off = cyc_cnt - c0;
        rd = u_s.dat_r;
      end
    end
    @(posedge clk);
    #1;
    u_s.stb = 1'b0;
    u_s.cyc = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int ack_off;
    int nack;
    int c0;
    int t1;
    int t2;
    logic [31:0] rd;
    acc_t e_all [$];
    bit we;
    logic [31:0] adr;
    logic [3:0] sel;
    logic [31:0] dat;
    int L;

    reset = 1'b1;
    u_s.stb = 1'b0;
    u_s.cyc = 1'b0;
    u_s.we = 1'b0;
    u_s.adr = '0;
    u_s.sel = '0;
    u_s.dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_s_ack", {31'd0, u_s.ack}, 32'd0);
    check("rst_s_dat", u_s.dat_r, 32'd0);
    check("rst_m_stb", {31'd0, u_m.stb}, 32'd0);
    check("rst_m_cyc", {31'd0, u_m.cyc}, 32'd0);
    check("rst_m_we", {31'd0, u_m.we}, 32'd0);
    check("rst_m_adr", u_m.adr, 32'd0);
    check("rst_m_sel", {28'd0, u_m.sel}, 32'd0);
    check("rst_m_dat", u_m.dat_w, 32'd0);

    preload(32'h10, 32'h12345678);

    vt[0] = '{1'b1, 32'h10, 4'hF, 32'hAABBCCDD, 0, 6, 32'h0};
    vt[1] = '{1'b0, 32'h10, 4'hF, 32'h0, 0, 6, 32'hAABBCCDD};
    vt[2] = '{1'b0, 32'h40, 4'hF, 32'h0, 2, 10, 32'h12345678};
    vt[3] = '{1'b1, 32'h10, 4'h3, 32'h11112222, 0,
              SKIP ? 3 : 6, 32'h0};
    vt[4] = '{1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 0,
              SKIP ? 1 : 6, 32'h0};
    vt[5] = '{1'b1, 32'h10, 4'hC, 32'h33334444, 1,
              SKIP ? 4 : 8, 32'h0};
    vt[6] = '{1'b0, 32'h10, 4'hC, 32'h0, 1,
              SKIP ? 4 : 8, SKIP ? 32'h33330000 : 32'h33332222};
    vt[7] = '{1'b0, 32'h10, 4'h3, 32'h0, 7,
              SKIP ? 10 : 20, SKIP ? 32'h00002222 : 32'h33332222};

    for (int i = 0; i < 8; i++) begin
      model_txn(vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, vt[i].lat);
      run_txn(vt[i].we, vt[i].adr, vt[i].sel, vt[i].dat, vt[i].lat,
              ack_off, rd);
      check($sformatf("v%0d_ack", i), ack_off, vt[i].exp_ack);
      if (!vt[i].we) check($sformatf("v%0d_rd", i), rd, vt[i].exp_rd);
      compare_acc($sformatf("v%0d", i));
    end

    // reset while the odd half is in flight
    lat = 3;
    @(posedge clk);
    #1;
    acc_q.delete();
    rises = 0;
    drive_req(1'b0, 32'h40, 4'hF, 32'h0);
    c0 = cyc_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_odd_stb", {31'd0, u_m.stb}, 32'd1);
    check("rst_mid_odd_adr", u_m.adr, 32'h84);
    reset = 1'b1;
    u_s.stb = 1'b0;
    u_s.cyc = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc", cyc_cnt - c0, 32'd9);
    check("rst_mid_stb", {31'd0, u_m.stb}, 32'd0);
    check("rst_mid_ack", {31'd0, u_s.ack}, 32'd0);
    check("rst_mid_adr", u_m.adr, 32'd0);
    check("rst_mid_dat", u_s.dat_r, 32'd0);
    nack = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (u_s.ack === 1'b1) nack++;
    end
    check("rst_mid_no_ack", nack, 0);
    model_txn(1'b0, 32'h40, 4'hF, 32'h0, 0);
    run_txn(1'b0, 32'h40, 4'hF, 32'h0, 0, ack_off, rd);
    check("rst_after_ack", ack_off, 6);
    check("rst_after_rd", rd, 32'h12345678);
    compare_acc("rst_after");

    // upstream abort during the even access
    lat = 2;
    @(posedge clk);
    #1;
    acc_q.delete();
    rises = 0;
    drive_req(1'b1, 32'h80, 4'hF, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1;
    u_s.stb = 1'b0;
    u_s.cyc = 1'b0;
    nack = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_s.ack === 1'b1) nack++;
    end
    check("abort_no_ack", nack, 0);
    exp_q.delete();
    exp_q.push_back('{1'b1, 32'h100, 4'h3, 32'h0000DEAD});
    compare_acc("abort");
    ref_mem[32'h20] = 32'hDEAD0000;
    model_txn(1'b0, 32'h80, 4'hF, 32'h0, 0);
    run_txn(1'b0, 32'h80, 4'hF, 32'h0, 0, ack_off, rd);
    check("abort_rd", rd, 32'hDEAD0000);

    // two requests with strobe held high
    model_txn(1'b1, 32'h8, 4'hF, 32'h01020304, 0);
    e_all = exp_q;
    model_txn(1'b1, 32'hC, 4'hF, 32'h05060708, 0);
    foreach (exp_q[i]) e_all.push_back(exp_q[i]);
    exp_q = e_all;
    lat = 0;
    @(posedge clk);
    #1;
    acc_q.delete();
    rises = 0;
    drive_req(1'b1, 32'h8, 4'hF, 32'h01020304);
    c0 = cyc_cnt;
    nack = 0;
    t1 = -1;
    t2 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (u_s.ack === 1'b1) begin
        nack++;
        if (nack == 1) t1 = cyc_cnt - c0;
        if (nack == 2) t2 = cyc_cnt - c0;
      end
      @(posedge clk);
      #1;
      if (nack == 1) drive_req(1'b1, 32'hC, 4'hF, 32'h05060708);
      if (nack >= 2) begin
        u_s.stb = 1'b0;
        u_s.cyc = 1'b0;
      end
    end
    check("b2b_nack", nack, 2);
    check("b2b_t1", t1, 6);
    check("b2b_t2", t2, 13);
    compare_acc("b2b");

    // randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      adr = ($urandom & 32'hFFF8_0000) |
            (32'($urandom_range(0, 15)) << 2) |
            32'($urandom_range(0, 3));
      sel = 4'($urandom_range(0, 15));
      dat = $urandom;
      L = $urandom_range(0, 7);
      model_txn(we, adr, sel, dat, L);
      run_txn(we, adr, sel, dat, L, ack_off, rd);
      check($sformatf("r%0d_ack", i), ack_off, exp_ack);
      if (!we) check($sformatf("r%0d_rd", i), rd, exp_rd);
      compare_acc($sformatf("r%0d", i));
    end

    check("stb_after_ack", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
